spi_target_regfile: RTL and testbench

SPI mode-0 target that exposes a small byte-wide register file to an external SPI controller. It is the responder for the SoC's SPI controller port: it connects to sclk, ss, mosi and miso. A testbench or companion chip uses it as a register-mapped peripheral. All logic runs on the system clock; the SPI pins are oversampled and are not used as clocks.

---
 rtl/spi_target_regfile.sv | 157 +++++++++++++++
 tb/tb_spi_target_regfile.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_target_regfile.sv
// SPI mode-0 target with a byte-wide register file behind it.
// The SPI pins are oversampled on io_clock. Nothing in this block is clocked by sclk.
// Byte 0 of a transaction is the command: bit7 selects write (1) or read (0),
// and the low address bits give the start address.
// Each following byte is one data byte. The address auto-increments after
// every data byte and wraps around the register file.
module spi_target_regfile #(
  parameter int REG_COUNT  = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                   io_clock,
  input  logic                   io_reset,
  input  logic                   io_spi_sclk,
  input  logic                   io_spi_ss,
  input  logic                   io_spi_mosi,
  output logic                   io_spi_miso,
  output logic                   io_wrValid,
  output logic [ADDR_WIDTH-1:0]  io_wrAddr,
  output logic [7:0]             io_wrData,
  output logic [8*REG_COUNT-1:0] io_regs,
  output logic                   io_busy
);

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  state_t state, state_next;

  logic [1:0] sclk_sync, ss_sync, mosi_sync;
  logic       sclk_d, ss_d;
  logic       sclk_rise, sclk_fall, ss_rise, ss_fall;

  logic [2:0]            bit_cnt;
  logic [7:0]            shift_in;
  logic [7:0]            shift_out;
  logic [7:0]            full_byte;
  logic                  byte_done;
  logic                  rw_write;
  logic                  load_pending;
  logic [ADDR_WIDTH-1:0] addr;
  logic [7:0]            regs [REG_COUNT];

  // Two-flop synchronisers plus one delay stage for sclk/ss edge detection.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge io_clock or negedge io_reset) begin
    if (!io_reset) begin
      sclk_sync <= 2'b00;
      sclk_d    <= 1'b0;
      ss_sync   <= 2'b11;
      ss_d      <= 1'b1;
      mosi_sync <= 2'b00;
    end else begin
      sclk_sync <= {sclk_sync[0], io_spi_sclk};
      sclk_d    <= sclk_sync[1];
      ss_sync   <= {ss_sync[0], io_spi_ss};
      ss_d      <= ss_sync[1];
      mosi_sync <= {mosi_sync[0], io_spi_mosi};
    end
  end

  assign sclk_rise = sclk_sync[1] & ~sclk_d;
  assign sclk_fall = ~sclk_sync[1] & sclk_d;
  assign ss_rise   = ss_sync[1] & ~ss_d;
  assign ss_fall   = ~ss_sync[1] & ss_d;
  assign full_byte = {shift_in[6:0], mosi_sync[1]};
  assign byte_done = sclk_rise && (bit_cnt == 3'd7);

  // State register.
  always_ff @(posedge io_clock or negedge io_reset) begin
    if (!io_reset) state <= IDLE;
    else           state <= state_next;
  end

  // Next-state logic. A deselect always wins over a same-cycle sclk edge.
  // NOTE: default assignment first so no path through the case infers a latch.
  always_comb begin
    state_next = state;
    if (ss_rise) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (ss_fall)   state_next = CMD;
        CMD:     if (byte_done) state_next = DATA;
        DATA:    state_next = DATA;
        default: state_next = IDLE;
      endcase
    end
  end

  // Outputs decoded from state. miso is driven only in the data phase of a read.
  always_comb begin
    io_busy     = (state != IDLE);
    io_spi_miso = (state == DATA) && !rw_write && shift_out[7];
  end

  // Shift-in, command decode, register writes and the read shift-out path.
  // NOTE: the register file is built from flops and is cleared by reset like any other state.
  always_ff @(posedge io_clock or negedge io_reset) begin
    if (!io_reset) begin
      bit_cnt      <= 3'd0;
      shift_in     <= 8'h00;
      shift_out    <= 8'h00;
      rw_write     <= 1'b0;
      load_pending <= 1'b0;
      addr         <= '0;
      io_wrValid   <= 1'b0;
      io_wrAddr    <= '0;
      io_wrData    <= 8'h00;
      for (int k = 0; k < REG_COUNT; k++) regs[k] <= 8'h00;
    end else begin
      io_wrValid <= 1'b0;
      if (ss_rise) begin
        bit_cnt      <= 3'd0;
        load_pending <= 1'b0;
      end else if (state == IDLE) begin
        if (ss_fall) begin
          bit_cnt      <= 3'd0;
          shift_in     <= 8'h00;
          shift_out    <= 8'h00;
          load_pending <= 1'b0;
        end
      end else if (sclk_rise) begin
        bit_cnt  <= bit_cnt + 3'd1;
        shift_in <= full_byte;
        if (bit_cnt == 3'd7) begin
          if (state == CMD) begin
            addr         <= full_byte[ADDR_WIDTH-1:0];
            rw_write     <= full_byte[7];
            load_pending <= ~full_byte[7];
          end else if (rw_write) begin
            regs[addr] <= full_byte;
            io_wrValid <= 1'b1;
            io_wrAddr  <= addr;
            io_wrData  <= full_byte;
            addr       <= addr + 1'b1;
          end else begin
            // The read byte has been fully clocked out, so move to the next register.
            addr         <= addr + 1'b1;
            load_pending <= 1'b1;
          end
        end
      end else if (sclk_fall && (state == DATA) && !rw_write) begin
        if (load_pending) begin
          shift_out    <= regs[addr];
          load_pending <= 1'b0;
        end else begin
          shift_out <= {shift_out[6:0], 1'b0};
        end
      end
    end
  end

  // Flatten the register file onto io_regs.
  for (genvar k = 0; k < REG_COUNT; k++) begin : g_flat
    assign io_regs[8*k +: 8] = regs[k];
  end

endmodule

// File: tb/tb_spi_target_regfile.sv
// Testbench for spi_target_regfile.
// Directed transactions follow the intended use cases, then randomized
// transactions follow. Every result is compared against a register-array
// reference model.
module tb_spi_target_regfile;

  localparam int REG_COUNT  = 16;
  localparam int ADDR_WIDTH = 4;

  logic                   io_clock;
  logic                   io_reset;
  logic                   io_spi_sclk;
  logic                   io_spi_ss;
  logic                   io_spi_mosi;
  logic                   io_spi_miso;
  logic                   io_wrValid;
  logic [ADDR_WIDTH-1:0]  io_wrAddr;
  logic [7:0]             io_wrData;
  logic [8*REG_COUNT-1:0] io_regs;
  logic                   io_busy;

  spi_target_regfile #(.REG_COUNT(REG_COUNT), .ADDR_WIDTH(ADDR_WIDTH)) dut (
    .io_clock    (io_clock),
    .io_reset    (io_reset),
    .io_spi_sclk (io_spi_sclk),
    .io_spi_ss   (io_spi_ss),
    .io_spi_mosi (io_spi_mosi),
    .io_spi_miso (io_spi_miso),
    .io_wrValid  (io_wrValid),
    .io_wrAddr   (io_wrAddr),
    .io_wrData   (io_wrData),
    .io_regs     (io_regs),
    .io_busy     (io_busy)
  );

  // 100 MHz system clock.
  initial io_clock = 1'b0;
  always #5 io_clock = ~io_clock;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]            model_regs [REG_COUNT];
  logic [7:0]            tx_buf [8];
  logic [7:0]            rx_buf [8];
  logic [ADDR_WIDTH-1:0] ev_addr [$];
  logic [7:0]            ev_data [$];
  logic [7:0]            ev_reg  [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Capture every cycle of io_wrValid, together with the register value seen in that cycle.
  always @(negedge io_clock) begin
    if (io_wrValid) begin
      ev_addr.push_back(io_wrAddr);
      ev_data.push_back(io_wrData);
      ev_reg.push_back(io_regs[8*io_wrAddr +: 8]);
    end
  end

  // Shift nbits of tx, MSB first, at sclk = 10 MHz. Capture miso just before each rising edge.
  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      io_spi_mosi = tx[i];
      #50;
      rx[i] = io_spi_miso;
      io_spi_sclk = 1'b1;
      #50;
      io_spi_sclk = 1'b0;
    end
  endtask

  // Send nbytes full bytes from tx_buf, then optionally extra_bits of a partial byte.
  // Deselect, then hold ss high for 4 cycles.
  task automatic spi_txn(input int nbytes, input int extra_bits);
    logic [7:0] dummy;
    io_spi_ss = 1'b0;
    #50;
    for (int b = 0; b < nbytes; b++) begin
      spi_bits(tx_buf[b], 8, rx_buf[b]);
      if (b == 0) check("busy_mid", 32'(io_busy), 32'd1);
    end
    if (extra_bits > 0) spi_bits(tx_buf[nbytes], extra_bits, dummy);
    #50;
    io_spi_ss = 1'b1;
    #40;
  endtask

  // Run one transaction and compare it against the reference model.
  task automatic run_txn(input string tag, input int nbytes, input int extra_bits);
    logic [ADDR_WIDTH-1:0] exp_addr [$];
    logic [7:0]            exp_data [$];
    logic [7:0]            exp_rx   [8];
    logic                  is_write;
    int                    a;
    logic [7:0]            rx_or;
    ev_addr.delete();
    ev_data.delete();
    ev_reg.delete();
    is_write = tx_buf[0][7];
    a = int'(tx_buf[0][ADDR_WIDTH-1:0]);
    for (int b = 0; b < 8; b++) exp_rx[b] = 8'h00;
    for (int b = 1; b < nbytes; b++) begin
      if (is_write) begin
        model_regs[a] = tx_buf[b];
        exp_addr.push_back(ADDR_WIDTH'(a));
        exp_data.push_back(tx_buf[b]);
      end else begin
        exp_rx[b] = model_regs[a];
      end
      a = (a + 1) % REG_COUNT;
    end

    spi_txn(nbytes, extra_bits);

    check({tag, "_busy_idle"}, 32'(io_busy), 32'd0);
    check({tag, "_wr_count"}, 32'(ev_addr.size()), 32'(exp_addr.size()));
    if (ev_addr.size() == exp_addr.size()) begin
      foreach (exp_addr[i]) begin
        check({tag, "_wr_addr"}, 32'(ev_addr[i]), 32'(exp_addr[i]));
        check({tag, "_wr_data"}, 32'(ev_data[i]), 32'(exp_data[i]));
        check({tag, "_wr_regs"}, 32'(ev_reg[i]), 32'(exp_data[i]));
      end
    end
    if (nbytes > 0) check({tag, "_miso_cmd"}, 32'(rx_buf[0]), 32'd0);
    if (is_write) begin
      rx_or = 8'h00;
      for (int b = 0; b < nbytes; b++) rx_or = rx_or | rx_buf[b];
      check({tag, "_miso_wr"}, 32'(rx_or), 32'd0);
    end else begin
      for (int b = 1; b < nbytes; b++)
        check($sformatf("%s_rd%0d", tag, b), 32'(rx_buf[b]), 32'(exp_rx[b]));
    end
    for (int k = 0; k < REG_COUNT; k++)
      check($sformatf("%s_reg%0d", tag, k), 32'(io_regs[8*k +: 8]), 32'(model_regs[k]));
  endtask

  initial begin
    logic [7:0] dummy;
    int nb;
    int xb;
    io_reset    = 1'b0;
    io_spi_sclk = 1'b0;
    io_spi_ss   = 1'b1;
    io_spi_mosi = 1'b0;
    for (int k = 0; k < REG_COUNT; k++) model_regs[k] = 8'h00;
    #23;
    check("rst_miso",    32'(io_spi_miso), 32'd0);
    check("rst_busy",    32'(io_busy),     32'd0);
    check("rst_wrvalid", 32'(io_wrValid),  32'd0);
    check("rst_wraddr",  32'(io_wrAddr),   32'd0);
    check("rst_wrdata",  32'(io_wrData),   32'd0);
    check("rst_regs",    32'(io_regs != '0), 32'd0);
    io_reset = 1'b1;
    @(negedge io_clock);
    #50;

    // Single write to register 3.
    tx_buf[0] = 8'h83; tx_buf[1] = 8'hA5;
    run_txn("wr3", 2, 0);

    // Burst write wrapping from 15 to 0.
    tx_buf[0] = 8'h8E; tx_buf[1] = 8'h11; tx_buf[2] = 8'h22; tx_buf[3] = 8'h33;
    run_txn("burst", 4, 0);

    // Burst read from 15 (expect 0x22, 0x33, 0x00).
    tx_buf[0] = 8'h0F;
    for (int b = 1; b < 4; b++) tx_buf[b] = 8'($urandom);
    run_txn("rdburst", 4, 0);

    // Abort after 5 bits of the data byte.
    tx_buf[0] = 8'h82; tx_buf[1] = 8'hFF;
    run_txn("abort", 1, 5);

    // Reset in the middle of a read byte.
    tx_buf[0] = 8'h01; tx_buf[1] = 8'hC3;
    io_spi_ss = 1'b0;
    #50;
    spi_bits(8'h03, 8, dummy);
    spi_bits(8'h00, 3, dummy);
    io_reset = 1'b0;
    #1;
    check("mid_rst_miso", 32'(io_spi_miso), 32'd0);
    check("mid_rst_busy", 32'(io_busy), 32'd0);
    check("mid_rst_regs", 32'(io_regs != '0), 32'd0);
    for (int k = 0; k < REG_COUNT; k++) model_regs[k] = 8'h00;
    @(negedge io_clock);
    io_spi_ss   = 1'b1;
    io_spi_sclk = 1'b0;
    #20;
    io_reset = 1'b1;
    #50;
    tx_buf[0] = 8'h81; tx_buf[1] = 8'h5A;
    run_txn("post_rst", 2, 0);

    // Back-to-back transactions. The second address comes only from its own command.
    tx_buf[0] = 8'h85; tx_buf[1] = 8'h77;
    run_txn("b2b_wr", 2, 0);
    tx_buf[0] = 8'h03;
    for (int b = 1; b < 4; b++) tx_buf[b] = 8'($urandom);
    run_txn("b2b_rd", 4, 0);

    // Randomized transactions.
    for (int t = 0; t < 40; t++) begin
      nb = int'($urandom_range(1, 6));
      xb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
      for (int b = 0; b < 8; b++) tx_buf[b] = 8'($urandom);
      run_txn($sformatf("rnd%0d", t), nb, xb);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
